dsp_post_adder_acc: RTL
=======================

Name: dsp_post_adder_acc

Overview:
- Post-adder/accumulator stage of the DSP48A1 slice. Sits directly downstream of the M (multiplier) and C pipeline registers and consumes their outputs.
- Selects X and Z operands under OPMODE control, performs add/subtract with carry-in, and holds the result in the P register with accumulate feedback.
- Drives P, the PCOUT cascade and the carry outputs.

Parameters:
- PREG, 1, 1 = P and CARRYOUT registered; 0 = combinational.
- OPMODEREG, 1, 1 = opmode captured in a register; 0 = opmode used directly.
- CARRYINREG, 1, 1 = carryin registered; 0 = direct.

Ports:
- CLK  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low; clears all internal registers.
- ce_opmode  in  1  clock enable, opmode register.
- ce_carryin  in  1  clock enable, carryin register.
- ce_p  in  1  clock enable, P and CARRYOUT registers.
- opmode  in  5  [1:0] X select, [3:2] Z select, [4] subtract.
- m_in  in  36  signed product from M stage.
- c_in  in  48  C operand from C stage.
- dab_in  in  48  concatenated {D[11:0],A[17:0],B[17:0]}.
- pcin  in  48  cascade input from previous slice.
- carryin  in  1  carry input.
- p  out  48  result.
- pcout  out  48  cascade output, always equal to p.
- carryout  out  1  carry/borrow of result.
- carryoutf  out  1  fabric copy, always equal to carryout.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - p, pcout, carryout, carryoutf, the opmode register and the carryin register all go to 0 immediately.
  - Reset dominates every clock enable.
- Effective opmode/carryin:
  - Registered value when OPMODEREG/CARRYINREG=1; the register updates only when its ce=1.
  - Raw input when the parameter is 0.
- X mux:
  - 0 selects 0.
  - 1 selects m_in sign-extended to 48 bits.
  - 2 selects P feedback.
  - 3 selects dab_in.
- Z mux:
  - 0 selects 0.
  - 1 selects pcin.
  - 2 selects P feedback.
  - 3 selects c_in.
- Arithmetic (49-bit, zero-extended operands):
  - subtract=0: R = Z + X + cin.
  - subtract=1: R = Z - X - cin.
  - Result = R[47:0]; carry = R[48], which is a borrow indication when subtracting.
  - Wrap-around is modulo 2^48. No saturation.
- P register (PREG=1):
  - On CLK rise with ce_p=1: p <= Result, carryout <= carry.
  - With ce_p=0: p and carryout hold.
  - Latency is 1 cycle from operand/opmode change to p.
- PREG=0:
  - p and carryout are combinational.
  - P-feedback selections (X=2 or Z=2) evaluate as 0 to avoid a combinational loop.
- Same-edge ordering:
  - When opmode changes on the same edge that P captures, P uses the effective opmode in force before that edge.
  - With OPMODEREG=1, a new opmode therefore takes effect one cycle after ce_opmode samples it.
- Accumulation: with X=1 and Z=2, each enabled edge adds m_in to p.
- Reset mid-accumulation: p is zeroed at once. The first enabled edge after rst_n rises computes with a P feedback of 0.
- pcout = p and carryoutf = carryout at all times, with no extra delay.

Test Plan:
- Reset: assert rst_n=0 mid-cycle while p=0x123 → p, carryout go to 0 without a clock edge; after release with ce_p=0, p stays 0.
- Multiply-add: OPMODEREG=0, opmode=5'b01101, m_in=36'd10, c_in=48'd5, carryin=1, ce_p=1 → p=16 after 1 edge, carryout=0.
- Accumulate: opmode=5'b01001, m_in=-3 (36'hFFFFFFFFD), 4 enabled edges from p=0 → p=0xFFFFFFFFFFF4 (-12); drop ce_p for 2 edges → p holds.
- Subtract/borrow: opmode=5'b11111, c_in=2, dab_in=5, carryin=0 → p=0xFFFFFFFFFFFD, carryout=1. Then c_in=7 → p=2, carryout=0.
- Overflow wrap: opmode=5'b01111, c_in=0xFFFFFFFFFFFF, dab_in=1 → p=0, carryout=1.
- Opmode register timing: OPMODEREG=1; switch opmode from add to subtract with ce_opmode=1 at edge N → the P result at edge N reflects the old add; edge N+1 reflects subtract. With ce_opmode=0 the switch never takes effect.

Source files
------------

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1-style post-adder/accumulator: X/Z operand muxes, add/subtract with carry-in,
// P register with accumulate feedback, PCOUT cascade and carry outputs.
module dsp_post_adder_acc #(
  parameter int PREG       = 1,
  parameter int OPMODEREG  = 1,
  parameter int CARRYINREG = 1
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               ce_opmode,
  input  logic               ce_carryin,
  input  logic               ce_p,
  input  logic [4:0]         opmode,
  input  logic signed [35:0] m_in,
  input  logic [47:0]        c_in,
  input  logic [47:0]        dab_in,
  input  logic [47:0]        pcin,
  input  logic               carryin,
  output logic [47:0]        p,
  output logic [47:0]        pcout,
  output logic               carryout,
  output logic               carryoutf
);

  logic [4:0]  opmode_eff;
  logic        cin_eff;
  logic [47:0] p_fb;
  logic [47:0] x_mux;
  logic [47:0] z_mux;
  logic [48:0] sum;
  logic [47:0] p_d;
  logic        co_d;
  logic [47:0] p_int;
  logic        co_int;

  // 49-bit add/subtract on zero-extended operands; bit 48 is carry (or borrow).
  function automatic logic [48:0] post_add(input logic [47:0] z, input logic [47:0] x,
                                           input logic cin, input logic sub);
    logic [48:0] z_ext;
    logic [48:0] x_ext;
    logic [48:0] c_ext;
    z_ext = {1'b0, z};
    x_ext = {1'b0, x};
    c_ext = {48'd0, cin};
    if (sub) post_add = z_ext - x_ext - c_ext;
    else     post_add = z_ext + x_ext + c_ext;
  endfunction

  // Stage: optional opmode register
  generate
    if (OPMODEREG != 0) begin : g_opreg
      logic [4:0] opmode_q;
      always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)         opmode_q <= '0;
        else if (ce_opmode) opmode_q <= opmode;
      end
      assign opmode_eff = opmode_q;
    end else begin : g_opdir
      logic unused_ce_opmode;
      assign unused_ce_opmode = ce_opmode;
      assign opmode_eff = opmode;
    end
  endgenerate

  // Stage: optional carry-in register
  generate
    if (CARRYINREG != 0) begin : g_cireg
      logic cin_q;
      always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)          cin_q <= 1'b0;
        else if (ce_carryin) cin_q <= carryin;
      end
      assign cin_eff = cin_q;
    end else begin : g_cidir
      logic unused_ce_carryin;
      assign unused_ce_carryin = ce_carryin;
      assign cin_eff = carryin;
    end
  endgenerate

  always_comb begin
    x_mux = '0;
    case (opmode_eff[1:0])
      2'd0: x_mux = '0;
      2'd1: x_mux = {{12{m_in[35]}}, m_in};
      2'd2: x_mux = p_fb;
      2'd3: x_mux = dab_in;
      default: x_mux = '0;
    endcase
  end

  always_comb begin
    z_mux = '0;
    case (opmode_eff[3:2])
      2'd0: z_mux = '0;
      2'd1: z_mux = pcin;
      2'd2: z_mux = p_fb;
      2'd3: z_mux = c_in;
      default: z_mux = '0;
    endcase
  end

  assign sum  = post_add(z_mux, x_mux, cin_eff, opmode_eff[4]);
  assign p_d  = sum[47:0];
  assign co_d = sum[48];

  // Stage: P / CARRYOUT register; without it, feedback reads as 0 to break the loop
  generate
    if (PREG != 0) begin : g_preg
      logic [47:0] p_q;
      logic        co_q;
      always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
          p_q  <= '0;
          co_q <= 1'b0;
        end else if (ce_p) begin
          p_q  <= p_d;
          co_q <= co_d;
        end
      end
      assign p_fb   = p_q;
      assign p_int  = p_q;
      assign co_int = co_q;
    end else begin : g_pcomb
      logic unused_ce_p;
      assign unused_ce_p = ce_p;
      assign p_fb   = '0;
      assign p_int  = p_d;
      assign co_int = co_d;
    end
  endgenerate

  assign p         = p_int;
  assign pcout     = p_int;
  assign carryout  = co_int;
  assign carryoutf = co_int;

endmodule
